// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, re-aligns one-cycle-latency memory data with its PC.
// Optional FETCH_PERF_EN adds fetch/stall counters.
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic [63:0] PCOut,
   input  logic [31:0] ins_in,
   output logic [63:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   logic [63:0] pcout_d;
   logic [63:0] pc_m, pc_m_d;
   logic        valid_m, valid_m_d;
   logic [31:0] skid, skid_d;
   logic        skid_valid, skid_valid_d;
   logic [63:0] ifid_pc_d;
   logic [31:0] ifid_instr_d;
   logic        ifid_valid_d;

   // Redirect targets are word aligned; the low bits are dropped.
   logic unused_tgt;
   assign unused_tgt = ^branch_target[1:0];

   always_comb begin
      pcout_d      = PCOut;
      pc_m_d       = pc_m;
      valid_m_d    = valid_m;
      skid_d       = skid;
      skid_valid_d = skid_valid;
      ifid_pc_d    = ifid_pc;
      ifid_instr_d = ifid_instr;
      ifid_valid_d = ifid_valid;
      if (branch_taken) begin
         pcout_d      = {branch_target[63:2], 2'b00};
         valid_m_d    = 1'b0;
         skid_valid_d = 1'b0;
         ifid_valid_d = 1'b0;
      end else if (stall) begin
         // Memory output is overwritten at this edge; keep the word belonging to pc_m.
         if (!skid_valid) begin
            skid_d       = ins_in;
            skid_valid_d = 1'b1;
         end
      end else begin
         ifid_pc_d    = pc_m;
         ifid_valid_d = valid_m;
         ifid_instr_d = skid_valid ? skid : ins_in;
         pc_m_d       = PCOut;
         valid_m_d    = 1'b1;
         skid_valid_d = 1'b0;
         pcout_d      = PCOut + 64'(PC_STEP);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         PCOut      <= RESET_PC;
         pc_m       <= 64'h0;
         valid_m    <= 1'b0;
         skid       <= 32'h0;
         skid_valid <= 1'b0;
         ifid_pc    <= 64'h0;
         ifid_instr <= 32'h0;
         ifid_valid <= 1'b0;
      end else begin
         PCOut      <= pcout_d;
         pc_m       <= pc_m_d;
         valid_m    <= valid_m_d;
         skid       <= skid_d;
         skid_valid <= skid_valid_d;
         ifid_pc    <= ifid_pc_d;
         ifid_instr <= ifid_instr_d;
         ifid_valid <= ifid_valid_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic fetch_inc, stall_inc;
   assign fetch_inc = !branch_taken && !stall && valid_m;
   assign stall_inc = stall && !branch_taken;

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_cnt <= 32'h0;
         stall_cnt <= 32'h0;
      end else begin
         if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
         if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed program checks plus randomized
// stall/redirect/reset traffic against a PC-sequence model. Honors FETCH_PERF_EN.
module tb_if_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] PCOut;
   logic [31:0] ins_in;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, stall_cnt;
`endif

   if_fetch_stage #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .PCOut         (PCOut),
      .ins_in        (ins_in),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr),
      .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_EN
      ,
      .fetch_cnt     (fetch_cnt),
      .stall_cnt     (stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   // 64-word instruction memory, aliased on address bits [7:2].
   logic [31:0] im [64];
   initial begin
      for (int i = 0; i < 64; i++) im[i] = {8'hC0, 24'(i * 32'h00010203)};
      im[0]  = 32'hF84083E1;
      im[1]  = 32'hF84103E2;
      im[2]  = 32'hF84183E3;
      im[3]  = 32'hF84203E4;
      im[4]  = 32'hF84283E5;
      im[12] = 32'h8B030022;
      im[13] = 32'hCB0400A6;
   end

   always @(posedge clock) ins_in <= im[PCOut[7:2]];

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: the entry in IF/ID is always (pc, IM[pc]) for the PC fetched two useful edges earlier.
   logic [63:0] m_fetch, m_pcm, m_ipc;
   logic [31:0] m_iins;
   logic        m_vm, m_iv, m_rst;
   logic [31:0] m_fc, m_sc;

   always @(posedge clock) begin
      if (reset) begin
         m_fetch = 64'h0; m_pcm = 64'h0; m_vm = 1'b0;
         m_ipc = 64'h0; m_iins = 32'h0; m_iv = 1'b0; m_rst = 1'b1;
         m_fc = 32'h0; m_sc = 32'h0;
      end else if (branch_taken) begin
         m_fetch = branch_target & ~64'h3;
         m_vm = 1'b0;
         m_iv = 1'b0;
      end else if (stall) begin
         m_sc = m_sc + 32'd1;
      end else begin
         if (m_vm) m_fc = m_fc + 32'd1;
         m_ipc = m_pcm; m_iins = im[m_pcm[7:2]]; m_iv = m_vm;
         m_pcm = m_fetch; m_vm = 1'b1;
         m_fetch = m_fetch + 64'd4;
         m_rst = 1'b0;
      end
      #1;
      chk("PCOut", PCOut, m_fetch);
      chk("ifid_valid", 64'(ifid_valid), 64'(m_iv));
      if (m_iv || m_rst) begin
         chk("ifid_pc", ifid_pc, m_ipc);
         chk("ifid_instr", 64'(ifid_instr), 64'(m_iins));
      end
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", 64'(fetch_cnt), 64'(m_fc));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
`endif
   end

   task automatic tick();
      @(posedge clock);
      #3;
   endtask

   task automatic entry(input string name, input logic [63:0] pc, input logic [31:0] ins);
      chk({name, "_valid"}, 64'(ifid_valid), 64'd1);
      chk({name, "_pc"}, ifid_pc, pc);
      chk({name, "_instr"}, 64'(ifid_instr), 64'(ins));
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
      // Reset sequence and first fetches.
      tick(); tick();
      chk("rst_pcout", PCOut, 64'h0);
      chk("rst_valid", 64'(ifid_valid), 64'd0);
      reset = 1'b0;
      tick();
      chk("lat1_valid", 64'(ifid_valid), 64'd0);
      tick();
      entry("first", 64'd0, 32'hF84083E1);
      tick();
      entry("second", 64'd4, 32'hF84103E2);
      // Three-cycle stall holds everything.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         entry("stall_hold", 64'd4, 32'hF84103E2);
         chk("stall_pcout", PCOut, 64'd12);
      end
      stall = 1'b0;
      tick(); entry("rel8", 64'd8, 32'hF84183E3);
      tick(); entry("rel12", 64'd12, 32'hF84203E4);
      tick(); entry("rel16", 64'd16, 32'hF84283E5);
      // Redirect to 48.
      branch_taken = 1'b1; branch_target = 64'd48;
      tick();
      chk("br_bubble1", 64'(ifid_valid), 64'd0);
      chk("br_pcout", PCOut, 64'd48);
      branch_taken = 1'b0;
      tick(); chk("br_bubble2", 64'(ifid_valid), 64'd0);
      tick(); entry("tgt48", 64'd48, 32'h8B030022);
      tick(); entry("tgt52", 64'd52, 32'hCB0400A6);
      // Redirect beats stall; low bits dropped.
      branch_taken = 1'b1; stall = 1'b1; branch_target = 64'd50;
      tick();
      chk("brst_pcout", PCOut, 64'd48);
      branch_taken = 1'b0; stall = 1'b0;
      tick(); tick();
      entry("brst48", 64'd48, 32'h8B030022);
      // PC wraps at 2^64.
      branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFF9;
      tick();
      chk("wrap_a", PCOut, 64'hFFFF_FFFF_FFFF_FFF8);
      branch_taken = 1'b0;
      tick(); chk("wrap_b", PCOut, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(); chk("wrap_c", PCOut, 64'h0);
      // Reset during a stall with the skid loaded.
      stall = 1'b1;
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rs_pcout", PCOut, 64'h0);
      chk("rs_valid", 64'(ifid_valid), 64'd0);
      chk("rs_pc", ifid_pc, 64'h0);
      chk("rs_instr", 64'(ifid_instr), 64'h0);
      reset = 1'b0; stall = 1'b0;
      tick(); tick();
      entry("rs_first", 64'd0, 32'hF84083E1);
`ifdef FETCH_PERF_EN
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      for (int i = 0; i < 10; i++) tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      stall = 1'b0;
      chk("perf_fetch", 64'(fetch_cnt), 64'd11);
      chk("perf_stall", 64'(stall_cnt), 64'd3);
`endif
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         reset        = ($urandom_range(0, 199) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 7) == 0)
            branch_target = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom_range(0, 255))};
         else
            branch_target = 64'($urandom_range(0, 255));
         tick();
      end
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      tick(); tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
